// File: rtl/lt24_bus_decoder.sv
// LT24 (ILI9341) 8080 write-bus receiver: synchronizes the bus, decodes window and RAM-write
// commands, and streams one (x, y, rgb565) beat per written pixel through a 1-deep output register.
module lt24_bus_decoder #(
  parameter int H_RES       = 240,
  parameter int V_RES       = 320,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] lcd_data_in,
  input  logic        lcd_command_data,
  input  logic        lcd_write,
  input  logic        lcd_chipselect,
  input  logic        lcd_reset_x,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic [7:0]  last_cmd,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam logic [15:0] COL_END_RST  = 16'(H_RES - 1);
  localparam logic [15:0] PAGE_END_RST = 16'(V_RES - 1);
  // Bus word layout {resx, csx, dcx, wrx, data}; idle = all strobes deasserted
  localparam logic [19:0] BUS_IDLE     = 20'hF_0000;

  typedef enum logic [1:0] {IDLE, CASET, PASET, RAMWR} stateT;

  logic [19:0] busSync_q [SYNC_STAGES];
  logic        wrxPrev_q;
  logic        resxS, csxS, dcxS, wrxS;
  logic [15:0] dataS;
  logic        writeEdge;
  logic        unusedDataHi;

  stateT       state_q;
  logic [1:0]  paramIdx_q;
  logic [23:0] paramBuf_q;
  logic [15:0] colStart_q, colEnd_q, pageStart_q, pageEnd_q;
  logic [15:0] curX_q, curY_q;
  logic [15:0] nextX_d, nextY_d;
  logic        lastPix;
  logic        evt_q, evtDcx_q;
  logic [15:0] evtData_q;
  logic        evtLive, pixEvt, pixLoad, pixDrop;
  logic        pixValid_q, frameDone_q, overflow_q;
  logic [15:0] pixX_q, pixY_q, pixData_q;
  logic [7:0]  lastCmd_q;

  assign unusedDataHi = ^lcd_data_in[17:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) busSync_q[i] <= BUS_IDLE;
      wrxPrev_q <= 1'b1;
    end else begin
      busSync_q[0] <= {lcd_reset_x, lcd_chipselect, lcd_command_data, lcd_write, lcd_data_in[15:0]};
      for (int i = 1; i < SYNC_STAGES; i++) busSync_q[i] <= busSync_q[i-1];
      wrxPrev_q <= busSync_q[SYNC_STAGES-1][16];
    end
  end

  assign resxS     = busSync_q[SYNC_STAGES-1][19];
  assign csxS      = busSync_q[SYNC_STAGES-1][18];
  assign dcxS      = busSync_q[SYNC_STAGES-1][17];
  assign wrxS      = busSync_q[SYNC_STAGES-1][16];
  assign dataS     = busSync_q[SYNC_STAGES-1][15:0];
  assign writeEdge = ~wrxPrev_q & wrxS & ~csxS & resxS;

  // Raster pointer step: column wraps into the next page, page wraps to the window top
  always_comb begin
    lastPix = (curX_q == colEnd_q) && (curY_q == pageEnd_q);
    nextX_d = curX_q + 16'd1;
    nextY_d = curY_q;
    if (curX_q == colEnd_q) begin
      nextX_d = colStart_q;
      nextY_d = (curY_q == pageEnd_q) ? pageStart_q : curY_q + 16'd1;
    end
  end

  assign evtLive = evt_q & resxS;
  assign pixEvt  = evtLive & evtDcx_q & (state_q == RAMWR);
  assign pixLoad = pixEvt & (~pixValid_q | pix_ready);
  assign pixDrop = pixEvt & pixValid_q & ~pix_ready;

  always_ff @(posedge clk) begin
    if (reset || !resxS) begin
      state_q     <= IDLE;
      paramIdx_q  <= 2'd0;
      paramBuf_q  <= 24'd0;
      colStart_q  <= 16'd0;
      colEnd_q    <= COL_END_RST;
      pageStart_q <= 16'd0;
      pageEnd_q   <= PAGE_END_RST;
      curX_q      <= 16'd0;
      curY_q      <= 16'd0;
      evt_q       <= 1'b0;
      evtDcx_q    <= 1'b0;
      evtData_q   <= 16'd0;
      pixValid_q  <= 1'b0;
      pixX_q      <= 16'd0;
      pixY_q      <= 16'd0;
      pixData_q   <= 16'd0;
      frameDone_q <= 1'b0;
    end else begin
      evt_q       <= writeEdge;
      evtDcx_q    <= dcxS;
      evtData_q   <= dataS;
      frameDone_q <= 1'b0;
      if (evt_q && !evtDcx_q) begin
        paramIdx_q <= 2'd0;
        case (evtData_q[7:0])
          8'h2A:   state_q <= CASET;
          8'h2B:   state_q <= PASET;
          8'h2C: begin
            state_q <= RAMWR;
            curX_q  <= colStart_q;
            curY_q  <= pageStart_q;
          end
          8'h3C:   state_q <= RAMWR;
          default: state_q <= IDLE;
        endcase
      end else if (evt_q) begin
        case (state_q)
          CASET, PASET: begin
            // First three bytes are buffered; the window commits only on the fourth
            if (paramIdx_q == 2'd3) begin
              if (state_q == CASET) begin
                colStart_q <= paramBuf_q[23:8];
                colEnd_q   <= {paramBuf_q[7:0], evtData_q[7:0]};
              end else begin
                pageStart_q <= paramBuf_q[23:8];
                pageEnd_q   <= {paramBuf_q[7:0], evtData_q[7:0]};
              end
              state_q    <= IDLE;
              paramIdx_q <= 2'd0;
            end else begin
              paramBuf_q <= {paramBuf_q[15:0], evtData_q[7:0]};
              paramIdx_q <= paramIdx_q + 2'd1;
            end
          end
          RAMWR: begin
            curX_q      <= nextX_d;
            curY_q      <= nextY_d;
            frameDone_q <= lastPix;
          end
          default: ;
        endcase
      end
      if (pixLoad) begin
        pixValid_q <= 1'b1;
        pixX_q     <= curX_q;
        pixY_q     <= curY_q;
        pixData_q  <= evtData_q;
      end else if (pixValid_q && pix_ready) begin
        pixValid_q <= 1'b0;
      end
    end
  end

  // Overflow and last command survive the RESX soft reset; only the hard reset clears them
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      lastCmd_q  <= 8'h00;
    end else begin
      if (pixDrop) overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
      if (evtLive && !evtDcx_q) lastCmd_q <= evtData_q[7:0];
    end
  end

  assign pix_valid  = pixValid_q;
  assign pix_x      = pixX_q;
  assign pix_y      = pixY_q;
  assign pix_data   = pixData_q;
  assign frame_done = frameDone_q;
  assign last_cmd   = lastCmd_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_lt24_bus_decoder.sv
// Self-checking bench for lt24_bus_decoder: a transaction-level model of the ILI9341 write
// protocol predicts every output each cycle; directed literal checks pin the model.
module tb_lt24_bus_decoder;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;
  localparam int HRES = 240;
  localparam int VRES = 320;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] lcdData;
  logic        lcdDcx, lcdWrx, lcdCsx, lcdResx;
  logic        pixReady, clrOverflow;
  logic        pix_valid, frame_done, overflow;
  logic [15:0] pix_x, pix_y, pix_data;
  logic [7:0]  last_cmd;

  always #5 clk = ~clk;

  lt24_bus_decoder #(.H_RES(HRES), .V_RES(VRES), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .lcd_data_in(lcdData), .lcd_command_data(lcdDcx),
    .lcd_write(lcdWrx), .lcd_chipselect(lcdCsx), .lcd_reset_x(lcdResx),
    .pix_valid(pix_valid), .pix_ready(pixReady), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .frame_done(frame_done), .last_cmd(last_cmd),
    .overflow(overflow), .clr_overflow(clrOverflow)
  );

  typedef struct { logic dcx; logic [15:0] data; int due; } BusEvt;
  typedef struct { logic [15:0] x; logic [15:0] y; logic [15:0] d; logic fd; } PixRec;

  BusEvt       evq[$];
  PixRec       loadLog[$];
  logic [7:0]  mParams[$];
  int          cycle = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  int          mMode;
  logic [15:0] mColS, mColE, mPageS, mPageE, mX, mY;
  logic [15:0] mPixX, mPixY, mPixD;
  logic        mValid, mOvf, mFd;
  logic [7:0]  mLastCmd;
  bit          checkEn = 0;
  bit          randReady = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic modelReset(input bit hard);
    mMode = 0;
    mParams.delete();
    mColS = 16'd0;  mColE = 16'(HRES - 1);
    mPageS = 16'd0; mPageE = 16'(VRES - 1);
    mX = 16'd0; mY = 16'd0;
    mValid = 1'b0; mFd = 1'b0;
    mPixX = 16'd0; mPixY = 16'd0; mPixD = 16'd0;
    if (hard) begin
      mOvf = 1'b0;
      mLastCmd = 8'h00;
      evq.delete();
    end
  endtask

  // Protocol model: each bus write takes effect LAT cycles after its WRX rising edge
  always @(posedge clk) begin : modelProc
    BusEvt       ev;
    logic        newPix, ovfSet, nfd;
    logic [15:0] nx, ny, nd;
    cycle++;
    newPix = 1'b0; ovfSet = 1'b0; nfd = 1'b0;
    nx = 16'd0; ny = 16'd0; nd = 16'd0;
    mFd = 1'b0;
    if (reset) begin
      modelReset(1'b1);
    end else begin
      if (evq.size() > 0 && evq[0].due == cycle) begin
        ev = evq.pop_front();
        if (!ev.dcx) begin
          mLastCmd = ev.data[7:0];
          mParams.delete();
          case (ev.data[7:0])
            8'h2A: mMode = 1;
            8'h2B: mMode = 2;
            8'h2C: begin mMode = 3; mX = mColS; mY = mPageS; end
            8'h3C: mMode = 3;
            default: mMode = 0;
          endcase
        end else if (mMode == 1 || mMode == 2) begin
          mParams.push_back(ev.data[7:0]);
          if (mParams.size() == 4) begin
            if (mMode == 1) begin
              mColS = {mParams[0], mParams[1]}; mColE = {mParams[2], mParams[3]};
            end else begin
              mPageS = {mParams[0], mParams[1]}; mPageE = {mParams[2], mParams[3]};
            end
            mParams.delete();
            mMode = 0;
          end
        end else if (mMode == 3) begin
          newPix = 1'b1;
          nx = mX; ny = mY; nd = ev.data;
          nfd = (mX == mColE) && (mY == mPageE);
          if (mX == mColE) begin
            mX = mColS;
            mY = (mY == mPageE) ? mPageS : mY + 16'd1;
          end else begin
            mX = mX + 16'd1;
          end
        end
      end
      if (newPix) begin
        mFd = nfd;
        if (!mValid || pixReady) begin
          mValid = 1'b1; mPixX = nx; mPixY = ny; mPixD = nd;
          loadLog.push_back('{x: nx, y: ny, d: nd, fd: nfd});
        end else begin
          mOvf = 1'b1;
          ovfSet = 1'b1;
        end
      end else if (mValid && pixReady) begin
        mValid = 1'b0;
      end
      if (!ovfSet && clrOverflow) mOvf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("pix_valid", 32'(pix_valid), 32'(mValid));
      checkOutput("pix_x", 32'(pix_x), 32'(mPixX));
      checkOutput("pix_y", 32'(pix_y), 32'(mPixY));
      checkOutput("pix_data", 32'(pix_data), 32'(mPixD));
      checkOutput("frame_done", 32'(frame_done), 32'(mFd));
      checkOutput("overflow", 32'(overflow), 32'(mOvf));
      checkOutput("last_cmd", 32'(last_cmd), 32'(mLastCmd));
    end
  end

  always @(negedge clk) begin
    if (randReady) begin
      if ($urandom_range(0, 7) == 0) pixReady = ~pixReady;
      clrOverflow = ($urandom_range(0, 19) == 0);
    end
  end

  // One 8080 write cycle on the pins; garbage on the unused upper data bits
  task automatic applyStimulus(input logic dcx, input logic [15:0] data);
    BusEvt ev;
    @(negedge clk);
    lcdDcx  = dcx;
    lcdData = {2'($urandom), data};
    lcdWrx  = 1'b0;
    repeat (3) @(negedge clk);
    lcdWrx = 1'b1;
    if (!lcdCsx && lcdResx) begin
      ev.dcx = dcx; ev.data = data; ev.due = cycle + LAT;
      evq.push_back(ev);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkLog(input int idx, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] d, input logic fd);
    if (idx >= loadLog.size()) begin
      checkOutput("log size", 32'(loadLog.size()), 32'(idx + 1));
    end else begin
      checkOutput("log x", 32'(loadLog[idx].x), 32'(x));
      checkOutput("log y", 32'(loadLog[idx].y), 32'(y));
      checkOutput("log data", 32'(loadLog[idx].d), 32'(d));
      checkOutput("log frame", 32'(loadLog[idx].fd), 32'(fd));
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic settle();
    repeat (LAT + 2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    lcdData = 18'd0; lcdDcx = 1'b1; lcdWrx = 1'b1; lcdCsx = 1'b0; lcdResx = 1'b1;
    pixReady = 1'b1; clrOverflow = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst pix_x", 32'(pix_x), 32'd0);
    checkOutput("rst pix_data", 32'(pix_data), 32'd0);
    checkOutput("rst frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst last_cmd", 32'(last_cmd), 32'd0);
    checkOutput("rst overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    checkEn = 1;

    // RAMWR on the default window
    loadLog.delete();
    applyStimulus(1'b0, 16'h002C);
    applyStimulus(1'b1, 16'hF800);
    applyStimulus(1'b1, 16'h07E0);
    applyStimulus(1'b1, 16'h001F);
    settle();
    checkLog(0, 16'd0, 16'd0, 16'hF800, 1'b0);
    checkLog(1, 16'd1, 16'd0, 16'h07E0, 1'b0);
    checkLog(2, 16'd2, 16'd0, 16'h001F, 1'b0);
    checkOutput("t1 pix_x", 32'(pix_x), 32'd2);
    checkOutput("t1 pix_data", 32'(pix_data), 32'h001F);

    // 2x2 window with wrap back to the top-left corner
    applyStimulus(1'b0, 16'h002A);
    applyStimulus(1'b1, 16'h0000); applyStimulus(1'b1, 16'h000A);
    applyStimulus(1'b1, 16'h0000); applyStimulus(1'b1, 16'h000B);
    applyStimulus(1'b0, 16'h002B);
    applyStimulus(1'b1, 16'h0000); applyStimulus(1'b1, 16'h0005);
    applyStimulus(1'b1, 16'h0000); applyStimulus(1'b1, 16'h0006);
    loadLog.delete();
    applyStimulus(1'b0, 16'h002C);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 16'(i));
    settle();
    checkLog(0, 16'd10, 16'd5, 16'd1, 1'b0);
    checkLog(1, 16'd11, 16'd5, 16'd2, 1'b0);
    checkLog(2, 16'd10, 16'd6, 16'd3, 1'b0);
    checkLog(3, 16'd11, 16'd6, 16'd4, 1'b1);
    checkLog(4, 16'd10, 16'd5, 16'd5, 1'b0);

    // Back-pressure: held pixel, overflow set then cleared
    doReset();
    pixReady = 1'b0;
    applyStimulus(1'b0, 16'h002C);
    applyStimulus(1'b1, 16'hAAAA);
    applyStimulus(1'b1, 16'hBBBB);
    settle();
    checkOutput("t3 held valid", 32'(pix_valid), 32'd1);
    checkOutput("t3 held x", 32'(pix_x), 32'd0);
    checkOutput("t3 held data", 32'(pix_data), 32'hAAAA);
    checkOutput("t3 overflow set", 32'(overflow), 32'd1);
    clrOverflow = 1'b1;
    @(negedge clk);
    clrOverflow = 1'b0;
    checkOutput("t3 overflow clr", 32'(overflow), 32'd0);
    pixReady = 1'b1;
    applyStimulus(1'b1, 16'hCCCC);
    settle();
    checkOutput("t3 next x", 32'(pix_x), 32'd2);
    checkOutput("t3 next y", 32'(pix_y), 32'd0);
    checkOutput("t3 next data", 32'(pix_data), 32'hCCCC);

    // Incomplete CASET is aborted by RAMWR
    applyStimulus(1'b0, 16'h002A);
    applyStimulus(1'b1, 16'h0000); applyStimulus(1'b1, 16'h0032);
    loadLog.delete();
    applyStimulus(1'b0, 16'h002C);
    applyStimulus(1'b1, 16'h1111);
    applyStimulus(1'b1, 16'h2222);
    settle();
    checkLog(0, 16'd0, 16'd0, 16'h1111, 1'b0);
    checkLog(1, 16'd1, 16'd0, 16'h2222, 1'b0);

    // WRX activity with CSX high, then with RESX low
    pixReady = 1'b0;
    applyStimulus(1'b1, 16'h3333);
    applyStimulus(1'b1, 16'h4444);
    settle();
    lcdCsx = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 16'h002B);
    applyStimulus(1'b1, 16'h5555);
    settle();
    checkOutput("t5 csx last_cmd", 32'(last_cmd), 32'h2C);
    checkOutput("t5 csx pix_x", 32'(pix_x), 32'd2);
    checkOutput("t5 csx pix_data", 32'(pix_data), 32'h3333);
    lcdCsx = 1'b0;
    repeat (4) @(negedge clk);
    checkEn = 0;
    lcdResx = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 16'h002A);
    applyStimulus(1'b1, 16'h6666);
    settle();
    checkOutput("t5 resx pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("t5 resx last_cmd", 32'(last_cmd), 32'h2C);
    checkOutput("t5 resx overflow", 32'(overflow), 32'd1);
    lcdResx = 1'b1;
    repeat (4) @(negedge clk);
    modelReset(1'b0);
    checkEn = 1;
    checkOutput("t5 soft pix_x", 32'(pix_x), 32'd0);
    pixReady = 1'b1;

    // Hard reset while a pixel is held
    applyStimulus(1'b0, 16'h002A);
    applyStimulus(1'b1, 16'h0000); applyStimulus(1'b1, 16'h0005);
    applyStimulus(1'b1, 16'h0000); applyStimulus(1'b1, 16'h0007);
    applyStimulus(1'b0, 16'h002C);
    pixReady = 1'b0;
    applyStimulus(1'b1, 16'h7777);
    applyStimulus(1'b1, 16'h8888);
    settle();
    checkOutput("t6 pre valid", 32'(pix_valid), 32'd1);
    checkOutput("t6 pre x", 32'(pix_x), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6 rst valid", 32'(pix_valid), 32'd0);
    checkOutput("t6 rst overflow", 32'(overflow), 32'd0);
    checkOutput("t6 rst last_cmd", 32'(last_cmd), 32'd0);
    reset = 1'b0;
    pixReady = 1'b1;
    applyStimulus(1'b0, 16'h002C);
    applyStimulus(1'b1, 16'h1234);
    settle();
    checkOutput("t6 default x", 32'(pix_x), 32'd0);
    checkOutput("t6 default y", 32'(pix_y), 32'd0);

    // Randomized traffic with random back-pressure and overflow clears
    randReady = 1;
    for (int n = 0; n < 300; n++) begin
      int r, s, e;
      r = $urandom_range(0, 99);
      if (r < 14) begin
        s = $urandom_range(0, 20);
        e = s + $urandom_range(0, 4);
        applyStimulus(1'b0, (r < 7) ? 16'h002A : 16'h002B);
        applyStimulus(1'b1, {8'($urandom), 8'(s >> 8)});
        applyStimulus(1'b1, {8'($urandom), 8'(s)});
        applyStimulus(1'b1, {8'($urandom), 8'(e >> 8)});
        applyStimulus(1'b1, {8'($urandom), 8'(e)});
      end else if (r < 18) begin
        applyStimulus(1'b0, (r < 16) ? 16'h002A : 16'h002B);
        applyStimulus(1'b1, 16'($urandom));
        applyStimulus(1'b1, 16'($urandom));
      end else if (r < 26) begin
        applyStimulus(1'b0, 16'h002C);
      end else if (r < 30) begin
        applyStimulus(1'b0, 16'h003C);
      end else if (r < 33) begin
        applyStimulus(1'b0, {8'($urandom), 8'h11});
      end else begin
        applyStimulus(1'b1, 16'($urandom));
      end
    end
    randReady = 0;
    pixReady = 1'b1;
    clrOverflow = 1'b0;
    repeat (10) @(negedge clk);
    checkEn = 0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
